wdt_ctrl: RTL and testbench
===========================

# wdt_ctrl

Supervisor that sits in front of the `wdt` watchdog timer. It collects per-client heartbeat pulses and issues one pet to the watchdog only once every monitored client has checked in. On a watchdog interrupt it escalates: it raises a CPU interrupt, waits a grace period for software acknowledge, then either recovers the watchdog or pulses a system reset. It also owns the watchdog's reset line, holding the timer in reset while supervision is disabled.

## Interface
Parameters:
- `N_CLIENTS`, default 4: number of heartbeat clients, 1..16.
- `GRACE_CNT`, default 1000: cycles allowed in ALARM for an acknowledge; must be ≥ 1.
- `RST_PULSE`, default 16: width of `sys_rst` in cycles; must be ≥ 1.

Ports:
- `clk`, input, 1: sole clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: supervision on/off (level).
- `client_mask`, input, N_CLIENTS: 1 = client is monitored (level, sampled every cycle).
- `client_alive`, input, N_CLIENTS: 1-cycle heartbeat pulse per client.
- `irq_ack`, input, 1: software acknowledge pulse.
- `wdt_irq`, input, 1: latched interrupt from `wdt`.
- `wdt_pet`, output, 1: 1-cycle pet pulse to `wdt`.
- `wdt_rst`, output, 1: synchronous reset to `wdt`.
- `alive_seen`, output, N_CLIENTS: clients checked in during the current round.
- `irq_out`, output, 1: CPU interrupt (level).
- `sys_rst`, output, 1: system reset pulse.

## Operation
- **States:** IDLE, MONITOR, PET, ALARM, RECOVER, SYSRST. State and all outputs are registered.
- **IDLE:**
  - `wdt_rst`=1 and `alive_seen`=0.
  - `enable`=1 → MONITOR.
- **MONITOR:**
  - `alive_seen <= alive_seen | (client_alive & client_mask)`.
  - If the next `alive_seen` covers `client_mask` and `client_mask` != 0 → PET.
  - `client_mask`=0 → never pets.
  - Unmasked clients' pulses are ignored.
- **PET (1 cycle):**
  - `wdt_pet`=1 and `alive_seen` cleared.
  - Heartbeats arriving in this cycle are recorded into the new round.
  - → MONITOR.
- **`wdt_irq`=1 in MONITOR or PET:**
  - → ALARM next cycle. This has priority over a PET transition; no pet is issued.
- **ALARM:**
  - `irq_out`=1; the grace counter counts from 0.
  - `irq_ack` → RECOVER.
  - Counter reaching `GRACE_CNT`-1 without ack → SYSRST.
  - Ack in the same cycle as the terminal count → RECOVER (ack wins).
- **RECOVER (1 cycle):**
  - `wdt_rst`=1, `irq_out`=0, `alive_seen` cleared.
  - → MONITOR.
- **SYSRST:**
  - `sys_rst`=1 for exactly `RST_PULSE` cycles, with `wdt_rst`=1 throughout.
  - `enable` and `irq_ack` are ignored.
  - → IDLE.
- **`enable`=0:**
  - In any state except SYSRST → IDLE next cycle, and `irq_out` is cleared.
- **Counter widths:** `$clog2(GRACE_CNT)+1` and `$clog2(RST_PULSE)+1` bits. Counters never wrap; they are cleared on every state entry.

## Timing
- **Reset values:** state=IDLE, `wdt_pet`=0, `wdt_rst`=1, `alive_seen`=0, `irq_out`=0, `sys_rst`=0.
- **Enable:** `enable` rises at cycle t → MONITOR at t+1, with `wdt_rst`=0 from t+1.
- **Pet:** the last required heartbeat at cycle t → `wdt_pet`=1 during t+1 only.
- **Alarm:** `wdt_irq` first high at t → `irq_out`=1 from t+1.
- **Acknowledge:** `irq_ack` at t → `wdt_rst`=1 at t+1, `irq_out`=0 at t+1, MONITOR at t+2.
- **No ack:** `sys_rst` rises `GRACE_CNT` cycles after ALARM entry.
- **`rst` mid-operation:** takes effect on the next edge from any state, including SYSRST, where it truncates the pulse.

## Structure
- **Shared package `wdt_pkg`:** the state encoding localparams (3-bit, IDLE=0). `wdt` and its software-visible register map reuse it.
- **Sub-module `wdt_ctrl_timer`:**
  - A cycle counter with `clear`/`run` inputs and a `done` output at a parameterised terminal value.
  - Instantiated twice: once for grace and once for reset pulse width.

## Test plan
- **Four heartbeats:** mask=4'b1111; alive pulses on clients 0, 1, 2, 3 at cycles 10, 20, 30, 40 → one `wdt_pet` pulse at cycle 41, and `alive_seen`=0 at 42.
- **Masked client:** mask=4'b0101; alive on clients 1 and 3 only → no pet and `alive_seen`=0. Then alive on clients 0 and 2 → pet.
- **Recovery:** `wdt_irq` high at cycle 100; `irq_ack` at cycle 150 → `irq_out` high over cycles 101–150. `wdt_rst` is high at 151. MONITOR at 152.
- **Escalation:** GRACE_CNT=8, RST_PULSE=4, no ack → `sys_rst` high for exactly 4 cycles starting 8 cycles after ALARM entry, then IDLE.
- **Simultaneous events:** all heartbeats and `wdt_irq` in the same cycle → ALARM and no pet. Separately, `irq_ack` on the terminal grace cycle → RECOVER with no `sys_rst`.
- **Reset and disable:** `rst` asserted in cycle 2 of SYSRST → `sys_rst`=0 and `wdt_rst`=1 next cycle. Dropping `enable` in ALARM → IDLE with `irq_out`=0.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: state encoding used by wdt_ctrl,
// the wdt timer and its software-visible register map.
package wdt_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MONITOR = 3'd1;
    localparam logic [2:0] ST_PET     = 3'd2;
    localparam logic [2:0] ST_ALARM   = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;
    localparam logic [2:0] ST_SYSRST  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_MONITOR = ST_MONITOR,
        S_PET     = ST_PET,
        S_ALARM   = ST_ALARM,
        S_RECOVER = ST_RECOVER,
        S_SYSRST  = ST_SYSRST
    } wdt_state_e;

endpackage

// File: rtl/wdt_ctrl_timer.sv
// Saturating cycle counter; done flags the terminal count TERM-1.
module wdt_ctrl_timer #(
    parameter int TERM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic done
);

    localparam int W = $clog2(TERM) + 1;
    localparam logic [W-1:0] LAST = W'(TERM - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !done) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog supervisor: gathers client heartbeats into a single pet
// and escalates watchdog interrupts to CPU irq, then system reset.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int GRACE_CNT = 1000,
    parameter int RST_PULSE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_CLIENTS-1:0] client_mask,
    input  logic [N_CLIENTS-1:0] client_alive,
    input  logic                 irq_ack,
    input  logic                 wdt_irq,
    output logic                 wdt_pet,
    output logic                 wdt_rst,
    output logic [N_CLIENTS-1:0] alive_seen,
    output logic                 irq_out,
    output logic                 sys_rst
);

    wdt_state_e state_q, state_d;

    logic [N_CLIENTS-1:0] seen_q, seen_d;
    logic [N_CLIENTS-1:0] hb, acc;
    logic pet_q, wrst_q, irq_q, sysrst_q;
    logic grace_done, pulse_done, covered;

    wdt_ctrl_timer #(.TERM(GRACE_CNT)) u_grace (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != S_ALARM),
        .run   (state_q == S_ALARM),
        .done  (grace_done)
    );

    wdt_ctrl_timer #(.TERM(RST_PULSE)) u_pulse (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != S_SYSRST),
        .run   (state_q == S_SYSRST),
        .done  (pulse_done)
    );

    assign hb = client_alive & client_mask;

    // PET opens a fresh round, so its heartbeats start the new set
    always_comb begin
        case (state_q)
            S_MONITOR: acc = seen_q | hb;
            S_PET:     acc = hb;
            default:   acc = seen_q;
        endcase
    end

    assign covered = (|client_mask)
                  && ((acc & client_mask) == client_mask);

    always_comb begin
        state_d = state_q;
        if (!enable && state_q != S_SYSRST) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_MONITOR;
                S_MONITOR: begin
                    if (wdt_irq)      state_d = S_ALARM;
                    else if (covered) state_d = S_PET;
                end
                S_PET: begin
                    state_d = wdt_irq ? S_ALARM : S_MONITOR;
                end
                S_ALARM: begin
                    if (irq_ack)         state_d = S_RECOVER;
                    else if (grace_done) state_d = S_SYSRST;
                end
                S_RECOVER: state_d = S_MONITOR;
                S_SYSRST: begin
                    if (pulse_done) state_d = S_IDLE;
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        seen_d = seen_q;
        case (state_d)
            S_IDLE, S_PET, S_RECOVER: seen_d = '0;
            S_MONITOR, S_ALARM: begin
                if (state_q == S_MONITOR || state_q == S_PET)
                    seen_d = acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            seen_q   <= '0;
            pet_q    <= 1'b0;
            wrst_q   <= 1'b1;
            irq_q    <= 1'b0;
            sysrst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seen_q   <= seen_d;
            pet_q    <= (state_d == S_PET);
            wrst_q   <= (state_d == S_IDLE)
                     || (state_d == S_RECOVER)
                     || (state_d == S_SYSRST);
            irq_q    <= (state_d == S_ALARM);
            sysrst_q <= (state_d == S_SYSRST);
        end
    end

    assign wdt_pet    = pet_q;
    assign wdt_rst    = wrst_q;
    assign alive_seen = seen_q;
    assign irq_out    = irq_q;
    assign sys_rst    = sysrst_q;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Bench for wdt_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_wdt_ctrl;

    localparam int N = 4;
    localparam int G = 8;
    localparam int R = 4;

    localparam int M_IDLE  = 0;
    localparam int M_MON   = 1;
    localparam int M_PET   = 2;
    localparam int M_ALARM = 3;
    localparam int M_REC   = 4;
    localparam int M_SYS   = 5;

    logic clk = 1'b0;
    logic rst, enable, irq_ack, wdt_irq;
    logic [N-1:0] client_mask, client_alive;
    logic wdt_pet, wdt_rst, irq_out, sys_rst;
    logic [N-1:0] alive_seen;

    int vecs = 0;
    int errs = 0;

    int m_mode = M_IDLE;
    int m_in = 0;
    logic [N-1:0] m_seen = '0;

    wdt_ctrl #(
        .N_CLIENTS (N),
        .GRACE_CNT (G),
        .RST_PULSE (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .client_mask  (client_mask),
        .client_alive (client_alive),
        .irq_ack      (irq_ack),
        .wdt_irq      (wdt_irq),
        .wdt_pet      (wdt_pet),
        .wdt_rst      (wdt_rst),
        .alive_seen   (alive_seen),
        .irq_out      (irq_out),
        .sys_rst      (sys_rst)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: mode plus cycles spent in it, advanced once per edge
    task automatic model_step();
        int nm;
        logic [N-1:0] acc;
        if (rst) begin
            m_mode = M_IDLE;
            m_seen = '0;
            m_in = 0;
            return;
        end
        acc = m_seen;
        if (m_mode == M_MON) acc = m_seen | (client_alive & client_mask);
        if (m_mode == M_PET) acc = client_alive & client_mask;
        nm = m_mode;
        if (m_mode != M_SYS && !enable) nm = M_IDLE;
        else begin
            case (m_mode)
                M_IDLE: nm = M_MON;
                M_MON: begin
                    if (wdt_irq) nm = M_ALARM;
                    else if (client_mask != 0
                             && (acc & client_mask) == client_mask)
                        nm = M_PET;
                end
                M_PET: nm = wdt_irq ? M_ALARM : M_MON;
                M_ALARM: begin
                    if (irq_ack) nm = M_REC;
                    else if (m_in == G - 1) nm = M_SYS;
                end
                M_REC: nm = M_MON;
                default: if (m_in == R - 1) nm = M_IDLE;
            endcase
        end
        if (nm == M_IDLE || nm == M_PET || nm == M_REC) m_seen = '0;
        else if (m_mode == M_MON || m_mode == M_PET) m_seen = acc;
        m_in = (nm == m_mode) ? m_in + 1 : 0;
        m_mode = nm;
    endtask

    task automatic step();
        logic [N+3:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {m_mode == M_PET,
               m_mode == M_IDLE || m_mode == M_REC || m_mode == M_SYS,
               m_seen, m_mode == M_ALARM, m_mode == M_SYS};
        check("model", 32'({wdt_pet, wdt_rst, alive_seen,
                            irq_out, sys_rst}), 32'(exp));
    endtask

    task automatic clear_pulses();
        client_alive = '0;
        irq_ack = 1'b0;
        wdt_irq = 1'b0;
        rst = 1'b0;
    endtask

    task automatic do_reset();
        clear_pulses();
        rst = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic rst, en;
        logic [N-1:0] mask, alive;
        logic ack, irq;
        logic pet, wrst;
        logic [N-1:0] seen;
        logic irqo, sys;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int npet, pcyc, cnt, rise;

        clear_pulses();
        enable = 1'b0;
        client_mask = 4'hF;

        // rst,en,mask,alive,ack,irq | pet,wrst,seen,irq_out,sys_rst
        tbl[0] = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0,
                   1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0,
                   1'b0, 1'b0, 4'h1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'hF, 4'h4, 1'b0, 1'b0,
                   1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0,
                   1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'hF, 4'h2, 1'b0, 1'b0,
                   1'b0, 1'b0, 4'h2, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1,
                   1'b0, 1'b0, 4'h2, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0,
                   1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0,
                   1'b0, 1'b1, 4'h0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            enable = tbl[i].en;
            client_mask = tbl[i].mask;
            client_alive = tbl[i].alive;
            irq_ack = tbl[i].ack;
            wdt_irq = tbl[i].irq;
            step();
            check($sformatf("tbl%0d", i),
                  32'({wdt_pet, wdt_rst, alive_seen, irq_out, sys_rst}),
                  32'({tbl[i].pet, tbl[i].wrst, tbl[i].seen,
                       tbl[i].irqo, tbl[i].sys}));
        end
        clear_pulses();

        // Four heartbeats spread out, one pet right after the last
        do_reset();
        check("rst_wdt_rst", 32'(wdt_rst), 32'd1);
        check("rst_outs", 32'({wdt_pet, alive_seen, irq_out, sys_rst}), 0);
        enable = 1'b1;
        client_mask = 4'hF;
        npet = 0;
        pcyc = -1;
        for (int k = 0; k <= 45; k++) begin
            client_alive = (k == 10) ? 4'h1 : (k == 20) ? 4'h2 :
                           (k == 30) ? 4'h4 : (k == 40) ? 4'h8 : 4'h0;
            step();
            if (k == 0) check("en_wdt_rst", 32'(wdt_rst), 32'd0);
            if (wdt_pet) begin
                npet++;
                pcyc = k + 1;
            end
            if (k == 41) check("hb_seen_clr", 32'(alive_seen), 32'd0);
        end
        check("hb_npet", 32'(npet), 32'd1);
        check("hb_petcyc", 32'(pcyc), 32'd41);

        // Unmasked clients do not count toward a pet
        client_mask = 4'h5;
        npet = 0;
        for (int k = 0; k < 6; k++) begin
            client_alive = (k == 1) ? 4'h2 : (k == 3) ? 4'h8 : 4'h0;
            step();
            if (wdt_pet) npet++;
        end
        check("mask_nopet", 32'(npet), 32'd0);
        check("mask_seen", 32'(alive_seen), 32'd0);
        client_alive = 4'h1;
        step();
        check("mask_seen0", 32'(alive_seen), 32'h1);
        client_alive = 4'h4;
        step();
        check("mask_pet", 32'(wdt_pet), 32'd1);
        client_alive = 4'h0;
        step();

        // Alarm acknowledged inside the grace window
        wdt_irq = 1'b1;
        step();
        wdt_irq = 1'b0;
        cnt = irq_out ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (irq_out) cnt++;
        end
        check("rec_irq_cnt", 32'(cnt), 32'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("rec_wdt_rst", 32'({wdt_rst, irq_out}), 32'b10);
        step();
        check("rec_monitor", 32'({wdt_rst, irq_out}), 32'b00);

        // No acknowledge: system reset pulse, enable ignored meanwhile
        wdt_irq = 1'b1;
        step();
        wdt_irq = 1'b0;
        rise = -1;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (sys_rst) begin
                if (rise < 0) rise = k;
                cnt++;
                check("esc_wdt_rst", 32'(wdt_rst), 32'd1);
                enable = 1'b0;
            end
        end
        check("esc_rise", 32'(rise), 32'd8);
        check("esc_width", 32'(cnt), 32'd4);
        check("esc_idle", 32'({wdt_rst, irq_out, sys_rst}), 32'b100);

        // Heartbeats and irq together; ack on the terminal grace cycle
        enable = 1'b1;
        client_mask = 4'hF;
        step();
        client_alive = 4'hF;
        wdt_irq = 1'b1;
        step();
        clear_pulses();
        check("sim_nopet", 32'({wdt_pet, irq_out}), 32'b01);
        for (int k = 0; k < 7; k++) step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("sim_ack_term", 32'({wdt_rst, irq_out, sys_rst}), 32'b100);
        step();

        // rst in the second SYSRST cycle truncates the pulse
        wdt_irq = 1'b1;
        step();
        wdt_irq = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check("rst_sys_on", 32'(sys_rst), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_sys_cut", 32'({sys_rst, wdt_rst}), 32'b01);

        // Dropping enable while alarmed
        step();
        wdt_irq = 1'b1;
        step();
        wdt_irq = 1'b0;
        check("dis_alarm", 32'(irq_out), 32'd1);
        enable = 1'b0;
        step();
        check("dis_idle", 32'({irq_out, wdt_rst}), 32'b01);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if (k % 16 == 0) client_mask = 4'($urandom);
            enable = ($urandom_range(0, 99) != 0);
            client_alive = ($urandom_range(0, 2) == 0) ?
                           4'($urandom) : 4'h0;
            wdt_irq = ($urandom_range(0, 29) == 0);
            irq_ack = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        clear_pulses();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
